mem_amo_unit: RTL and testbench

MEM-stage responder for atomic memory requests launched by the EXE/MEM pipeline register. It performs RV32A read-modify-write sequences (LR/SC and AMO*) against the single-port data memory. It also tracks the LR/SC reservation and stalls the pipeline until the atomic completes. The block sits beside the data memory port; while `amo_active` is high, the top-level mux hands the port to this block.

---
 rtl/mem_amo_unit_if.sv | 35 +++
 rtl/mem_amo_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_amo_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_amo_unit_if.sv
// Pipeline/data-memory bundle for the atomic responder: EXE/MEM request,
// memory port and completion signals.
interface mem_amo_unit_if #(
    parameter int DM_ADDR_BITS = 32
);
    logic                    mem_is_atomic;
    logic [3:0]              mem_atomic_op;
    logic [31:0]             mem_ALUout;
    logic [31:0]             mem_opB;
    logic                    mem_is_stype;
    logic [3:0]              mem_dm_write;
    logic [31:0]             dm_rdata;
    logic [DM_ADDR_BITS-1:0] dm_addr;
    logic [31:0]             dm_wdata;
    logic [3:0]              dm_we;
    logic                    amo_active;
    logic                    amo_stall;
    logic [31:0]             amo_result;
    logic                    amo_done;
    logic                    amo_misaligned;

    modport master (
        output mem_is_atomic, mem_atomic_op, mem_ALUout, mem_opB,
               mem_is_stype, mem_dm_write, dm_rdata,
        input  dm_addr, dm_wdata, dm_we, amo_active, amo_stall,
               amo_result, amo_done, amo_misaligned
    );

    modport slave (
        input  mem_is_atomic, mem_atomic_op, mem_ALUout, mem_opB,
               mem_is_stype, mem_dm_write, dm_rdata,
        output dm_addr, dm_wdata, dm_we, amo_active, amo_stall,
               amo_result, amo_done, amo_misaligned
    );
endinterface

// File: rtl/mem_amo_unit.sv
// RV32A LR/SC/AMO read-modify-write sequencer for the MEM-stage data port.
// Optional macro AMO_MINMAX_EN adds AMOMIN/MAX/MINU/MAXU; otherwise ops 7-10 act as reserved.
//
// state   | meaning
// IDLE    | wait for request; aligned: present read address, misaligned: go to DONE
// READ    | capture memory word, compute result/new value, update reservation
// WRITE   | write new value to memory
// DONE    | release stall, pulse amo_done with result
module mem_amo_unit #(
    parameter int DM_ADDR_BITS = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_amo_unit_if.slave  bus
);
    localparam logic [3:0] OP_LR   = 4'd0;
    localparam logic [3:0] OP_SC   = 4'd1;
    localparam logic [3:0] OP_SWAP = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
`ifdef AMO_MINMAX_EN
    localparam logic [3:0] OP_MIN  = 4'd7;
    localparam logic [3:0] OP_MAX  = 4'd8;
    localparam logic [3:0] OP_MINU = 4'd9;
    localparam logic [3:0] OP_MAXU = 4'd10;
`endif

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_new, r_result;
    logic        r_misal;
    logic        r_resv_valid;
    logic [29:0] r_resv_addr;

    logic [31:0] w_old, w_opb, w_new_val, w_res_val;
    logic        w_alu_write, w_is_lr, w_is_sc, w_resv_hit, w_snoop_clr;
    logic        w_load, w_misal_req;
    logic        w_stall, w_active, w_done, w_misal;
    logic [3:0]  w_we;
    logic [31:0] w_wdata, w_result, w_addr;

    assign w_old       = bus.dm_rdata;
    assign w_opb       = bus.mem_opB;
    assign w_resv_hit  = r_resv_valid && (r_resv_addr == bus.mem_ALUout[31:2]);
    assign w_snoop_clr = bus.mem_is_stype && (bus.mem_dm_write != 4'd0) && w_resv_hit;

    // Result/new-value datapath, only consumed while in READ.
    always_comb begin
        w_new_val   = w_opb;
        w_res_val   = w_old;
        w_alu_write = 1'b0;
        w_is_lr     = 1'b0;
        w_is_sc     = 1'b0;
        case (bus.mem_atomic_op)
            OP_LR:   w_is_lr = 1'b1;
            OP_SC: begin
                w_is_sc = 1'b1;
                if (w_resv_hit) begin
                    w_res_val   = 32'd0;
                    w_alu_write = 1'b1;
                end else begin
                    w_res_val = 32'd1;
                end
            end
            OP_SWAP: w_alu_write = 1'b1;
            OP_ADD: begin
                w_new_val   = w_old + w_opb;
                w_alu_write = 1'b1;
            end
            OP_XOR: begin
                w_new_val   = w_old ^ w_opb;
                w_alu_write = 1'b1;
            end
            OP_AND: begin
                w_new_val   = w_old & w_opb;
                w_alu_write = 1'b1;
            end
            OP_OR: begin
                w_new_val   = w_old | w_opb;
                w_alu_write = 1'b1;
            end
`ifdef AMO_MINMAX_EN
            OP_MIN: begin
                w_new_val   = ($signed(w_old) < $signed(w_opb)) ? w_old : w_opb;
                w_alu_write = 1'b1;
            end
            OP_MAX: begin
                w_new_val   = ($signed(w_old) > $signed(w_opb)) ? w_old : w_opb;
                w_alu_write = 1'b1;
            end
            OP_MINU: begin
                w_new_val   = (w_old < w_opb) ? w_old : w_opb;
                w_alu_write = 1'b1;
            end
            OP_MAXU: begin
                w_new_val   = (w_old > w_opb) ? w_old : w_opb;
                w_alu_write = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Outputs are forced low while rst is high so nothing reaches memory during reset.
    always_comb begin
        w_next      = r_state;
        w_stall     = 1'b0;
        w_active    = 1'b0;
        w_we        = 4'd0;
        w_wdata     = 32'd0;
        w_addr      = 32'd0;
        w_done      = 1'b0;
        w_misal     = 1'b0;
        w_result    = 32'd0;
        w_load      = 1'b0;
        w_misal_req = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_is_atomic) begin
                        w_stall = 1'b1;
                        if (bus.mem_ALUout[1:0] == 2'b00) begin
                            w_active = 1'b1;
                            w_addr   = {bus.mem_ALUout[31:2], 2'b00};
                            w_next   = S_READ;
                        end else begin
                            w_misal_req = 1'b1;
                            w_next      = S_DONE;
                        end
                    end
                end
                S_READ: begin
                    w_stall  = 1'b1;
                    w_active = 1'b1;
                    w_addr   = {bus.mem_ALUout[31:2], 2'b00};
                    w_load   = 1'b1;
                    w_next   = w_alu_write ? S_WRITE : S_DONE;
                end
                S_WRITE: begin
                    w_stall  = 1'b1;
                    w_active = 1'b1;
                    w_addr   = {bus.mem_ALUout[31:2], 2'b00};
                    w_we     = 4'b1111;
                    w_wdata  = r_new;
                    w_next   = S_DONE;
                end
                S_DONE: begin
                    w_done   = 1'b1;
                    w_misal  = r_misal;
                    w_result = r_result;
                    w_next   = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_new        <= 32'd0;
            r_result     <= 32'd0;
            r_misal      <= 1'b0;
            r_resv_valid <= 1'b0;
            r_resv_addr  <= 30'd0;
        end else begin
            r_state <= w_next;
            if (w_misal_req) begin
                r_misal  <= 1'b1;
                r_result <= 32'd0;
            end else if (r_state == S_DONE) begin
                r_misal <= 1'b0;
            end
            // r_result doubles as the captured "old" word for LR/AMO ops.
            if (w_load) begin
                r_new    <= w_new_val;
                r_result <= w_res_val;
            end
            if (w_load && w_is_lr) begin
                r_resv_valid <= 1'b1;
                r_resv_addr  <= bus.mem_ALUout[31:2];
            end else if ((w_load && w_is_sc) || w_snoop_clr) begin
                r_resv_valid <= 1'b0;
            end
        end
    end

    assign bus.dm_addr        = DM_ADDR_BITS'(w_addr);
    assign bus.dm_wdata       = w_wdata;
    assign bus.dm_we          = w_we;
    assign bus.amo_active     = w_active;
    assign bus.amo_stall      = w_stall;
    assign bus.amo_result     = w_result;
    assign bus.amo_done       = w_done;
    assign bus.amo_misaligned = w_misal;
endmodule

// File: tb/tb_mem_amo_unit.sv
// Directed bench for mem_amo_unit with a small word-addressed data memory model.
module tb_mem_amo_unit;
    localparam logic [3:0] LR = 4'd0, SC = 4'd1, SWAP = 4'd2, ADD = 4'd3, XOR = 4'd4,
                           AND = 4'd5, OR = 4'd6, MIN = 4'd7, MAX = 4'd8, MINU = 4'd9,
                           MAXU = 4'd10, RSVD = 4'd12;
`ifdef AMO_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_amo_unit_if #(.DM_ADDR_BITS(32)) bus();
    mem_amo_unit #(.DM_ADDR_BITS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [0:1023];
    logic        poke_en = 1'b0;
    logic [31:0] poke_addr = 32'd0, poke_data = 32'd0, sw_data = 32'd0;

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_addr[11:2]] <= poke_data;
        else if (bus.dm_we != 4'd0)
            mem[bus.dm_addr[11:2]] <= bus.dm_wdata;
        else if (bus.mem_is_stype && bus.mem_dm_write != 4'd0)
            mem[bus.mem_ALUout[11:2]] <= sw_data;
        bus.dm_rdata <= mem[bus.dm_addr[11:2]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        poke_en = 1'b1; poke_addr = addr; poke_data = data;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic do_atomic(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] opb,
                             output logic [31:0] res, output logic mis, output int stalls,
                             output int done_at, output logic we_seen);
        bit done;
        done = 0; stalls = 0; done_at = 0; we_seen = 0; res = 32'hDEAD_BEEF; mis = 1'b0;
        bus.mem_is_atomic = 1'b1; bus.mem_atomic_op = op; bus.mem_ALUout = addr; bus.mem_opB = opb;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (bus.amo_stall) stalls++;
            if (bus.dm_we != 4'd0) we_seen = 1'b1;
            if (bus.amo_done) begin
                done = 1; done_at = c + 1; res = bus.amo_result; mis = bus.amo_misaligned;
            end
            @(posedge clk); #1;
        end
        bus.mem_is_atomic = 1'b0;
        if (!done) chk("timeout_done", 32'd0, 32'd1);
    endtask

    task automatic amo_case(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] opb, input logic [31:0] exp_res, input int exp_stalls,
                            input logic exp_we, input logic [31:0] exp_mem);
        logic [31:0] res; logic mis, we_seen; int stalls, done_at;
        do_atomic(op, addr, opb, res, mis, stalls, done_at, we_seen);
        chk({tag, "_res"},    res, exp_res);
        chk({tag, "_stalls"}, stalls, exp_stalls);
        chk({tag, "_doneat"}, done_at, exp_stalls + 1);
        chk({tag, "_we"},     {31'd0, we_seen}, {31'd0, exp_we});
        chk({tag, "_mis"},    {31'd0, mis}, 32'd0);
        chk({tag, "_mem"},    mem[addr[11:2]], exp_mem);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"},  {31'd0, bus.amo_stall}, 32'd0);
        chk({tag, "_active"}, {31'd0, bus.amo_active}, 32'd0);
        chk({tag, "_done"},   {31'd0, bus.amo_done}, 32'd0);
        chk({tag, "_mis"},    {31'd0, bus.amo_misaligned}, 32'd0);
        chk({tag, "_we"},     {28'd0, bus.dm_we}, 32'd0);
        chk({tag, "_res"},    bus.amo_result, 32'd0);
        chk({tag, "_addr"},   bus.dm_addr, 32'd0);
        chk({tag, "_wdata"},  bus.dm_wdata, 32'd0);
    endtask

    typedef struct { logic [3:0] op; logic [31:0] exp_mem; } logic_vec_t;

    initial begin
        logic [31:0] res; logic mis, we_seen; int stalls, done_at;
        logic_vec_t lv [4];

        bus.mem_is_atomic = 1'b0; bus.mem_atomic_op = 4'd0; bus.mem_ALUout = 32'd0;
        bus.mem_opB = 32'd0; bus.mem_is_stype = 1'b0; bus.mem_dm_write = 4'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset");
        @(posedge clk); #1;

        poke(32'h100, 32'd5);
        amo_case("amoadd", ADD, 32'h100, 32'd7, 32'd5, 3, 1'b1, 32'd12);
        poke(32'h600, 32'hFFFF_FFFF);
        amo_case("add_wrap", ADD, 32'h600, 32'd2, 32'hFFFF_FFFF, 3, 1'b1, 32'd1);
        amo_case("reserved", RSVD, 32'h600, 32'd9, 32'd1, 2, 1'b0, 32'd1);

        poke(32'h200, 32'h55);
        amo_case("lr1", LR, 32'h200, 32'd0, 32'h55, 2, 1'b0, 32'h55);
        amo_case("sc_ok", SC, 32'h200, 32'hAA, 32'd0, 3, 1'b1, 32'hAA);
        amo_case("sc_again", SC, 32'h200, 32'hBB, 32'd1, 2, 1'b0, 32'hAA);

        amo_case("lr2", LR, 32'h200, 32'd0, 32'hAA, 2, 1'b0, 32'hAA);
        bus.mem_is_stype = 1'b1; bus.mem_dm_write = 4'hF; bus.mem_ALUout = 32'h200; sw_data = 32'h1234;
        @(posedge clk); #1;
        bus.mem_is_stype = 1'b0; bus.mem_dm_write = 4'd0;
        amo_case("sc_snooped", SC, 32'h200, 32'h77, 32'd1, 2, 1'b0, 32'h1234);

        lv[0] = '{SWAP, 32'h0FF0_0F0F};
        lv[1] = '{XOR,  32'hFF00_0FF0};
        lv[2] = '{AND,  32'h00F0_000F};
        lv[3] = '{OR,   32'hFFF0_0FFF};
        foreach (lv[i]) begin
            poke(32'h400, 32'hF0F0_00FF);
            amo_case($sformatf("logic_op%0d", lv[i].op), lv[i].op, 32'h400, 32'h0FF0_0F0F,
                     32'hF0F0_00FF, 3, 1'b1, lv[i].exp_mem);
        end

        poke(32'h300, 32'hFFFF_FFFF);
        amo_case("amomin", MIN, 32'h300, 32'd1, 32'hFFFF_FFFF, MM ? 3 : 2, MM, 32'hFFFF_FFFF);
        poke(32'h300, 32'hFFFF_FFFF);
        amo_case("amominu", MINU, 32'h300, 32'd1, 32'hFFFF_FFFF, MM ? 3 : 2, MM,
                 MM ? 32'd1 : 32'hFFFF_FFFF);
        poke(32'h300, 32'hFFFF_FFFF);
        amo_case("amomax", MAX, 32'h300, 32'd1, 32'hFFFF_FFFF, MM ? 3 : 2, MM,
                 MM ? 32'd1 : 32'hFFFF_FFFF);
        poke(32'h300, 32'hFFFF_FFFF);
        amo_case("amomaxu", MAXU, 32'h300, 32'd1, 32'hFFFF_FFFF, MM ? 3 : 2, MM, 32'hFFFF_FFFF);

        do_atomic(SWAP, 32'h102, 32'h99, res, mis, stalls, done_at, we_seen);
        chk("misal_flag",   {31'd0, mis}, 32'd1);
        chk("misal_res",    res, 32'd0);
        chk("misal_stalls", stalls, 32'd1);
        chk("misal_doneat", done_at, 32'd2);
        chk("misal_we",     {31'd0, we_seen}, 32'd0);
        chk("misal_mem",    mem[32'h100 >> 2], 32'd12);

        poke(32'h500, 32'h11);
        amo_case("lr3", LR, 32'h500, 32'd0, 32'h11, 2, 1'b0, 32'h11);
        bus.mem_is_atomic = 1'b1; bus.mem_atomic_op = XOR; bus.mem_ALUout = 32'h500; bus.mem_opB = 32'hFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("xor_in_write_we", {28'd0, bus.dm_we}, 32'hF);
        rst = 1'b1;
        #1;
        chk("xor_rst_we",    {28'd0, bus.dm_we}, 32'd0);
        chk("xor_rst_stall", {31'd0, bus.amo_stall}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_is_atomic = 1'b0;
        @(negedge clk);
        chk_quiet("after_rst");
        chk("xor_rst_mem", mem[32'h500 >> 2], 32'h11);
        @(posedge clk); #1;
        amo_case("sc_after_rst", SC, 32'h500, 32'h99, 32'd1, 2, 1'b0, 32'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
